// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request, response and multiplier-side signals of the
// two-requester multiply arbiter.
//   master : the arbiter (drives ready, response and multiplier controls)
//   slave  : the surroundings (requesters, response sink, multiply unit)
interface mult_arbiter_if #(
    parameter int WIDTH = 32
);
    // Requester 0
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_op1;
    logic [WIDTH-1:0]   req0_op2;
    logic               req0_ready;
    // Requester 1
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_op1;
    logic [WIDTH-1:0]   req1_op2;
    logic               req1_ready;
    // Shared response channel
    logic               rsp_valid;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_product;
    logic               rsp_err;
    // Multiply unit
    logic               mult_begin;
    logic [WIDTH-1:0]   mult_op1;
    logic [WIDTH-1:0]   mult_op2;
    logic [2*WIDTH-1:0] product;
    logic               mult_end;

    modport master (
        input  req0_valid, req0_op1, req0_op2,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_product, rsp_err,
        output mult_begin, mult_op1, mult_op2,
        input  product, mult_end
    );

    modport slave (
        output req0_valid, req0_op1, req0_op2,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_product, rsp_err,
        input  mult_begin, mult_op1, mult_op2,
        output product, mult_end
    );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one iterative multiply unit between two requesters.
// Round-robin grant in IDLE, level-sensitive mult_begin held through WAIT,
// product returned as a one-cycle rsp_valid pulse tagged with the owner.
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort an operation that
// has not finished after TIMEOUT cycles in WAIT (rsp_err=1, product 0).
module mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           resetn,
    mult_arbiter_if.master bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Parameter sanity: the abort compare needs at least one WAIT cycle.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mult_arbiter: TIMEOUT must be at least 2");
    end

    state_t           state_q, state_d;
    logic             mult_begin_q, mult_begin_d;
    logic [WIDTH-1:0] mult_op1_q, mult_op1_d;
    logic [WIDTH-1:0] mult_op2_q, mult_op2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [PW-1:0]    rsp_product_q, rsp_product_d;
    logic             rsp_err_q, rsp_err_d;
    logic             last_grant_q, last_grant_d;
    logic             grant0, grant1;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Round-robin grant: only in IDLE; on a tie the requester that did not
    // win last time is granted, so neither side can be starved.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d       = state_q;
        mult_begin_d  = mult_begin_q;
        mult_op1_d    = mult_op1_q;
        mult_op2_d    = mult_op2_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        last_grant_d  = last_grant_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    mult_op1_d   = bus.req0_op1;
                    mult_op2_d   = bus.req0_op2;
                    mult_begin_d = 1'b1;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else if (grant1) begin
                    mult_op1_d   = bus.req1_op1;
                    mult_op2_d   = bus.req1_op2;
                    mult_begin_d = 1'b1;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            WAIT: begin
                // mult_end is checked first so a completion on the abort
                // edge still returns the real product.
                if (bus.mult_end) begin
                    rsp_product_d = bus.product;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    mult_begin_d  = 1'b0;
                    state_d       = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_product_d = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    mult_begin_d  = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d         = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                // mult_begin is already low here and stays low through the
                // following IDLE cycle, giving the multiplier two idle cycles.
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mult_begin_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops mult_begin at once, which
    // also aborts the multiplier without producing a response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            mult_begin_q  <= 1'b0;
            mult_op1_q    <= '0;
            mult_op2_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            mult_begin_q  <= mult_begin_d;
            mult_op1_q    <= mult_op1_d;
            mult_op2_q    <= mult_op2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            last_grant_q  <= last_grant_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // WAIT-cycle counter for the abort timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mult_begin  = mult_begin_q;
    assign bus.mult_op1    = mult_op1_q;
    assign bus.mult_op2    = mult_op2_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench for mult_arbiter with a behavioural signed
// multiplier that raises mult_end d_lat cycles after mult_begin rises.
// Latency is counted in cycles from the handshake cycle (cycle 0) to the
// cycle in which rsp_valid is high.
module tb_mult_arbiter;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(W)) bus ();

    mult_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Behavioural multiplier
    int   d_lat = 33;
    int   m_cnt;
    logic m_end;
    logic stale_end = 1'b0;

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn || !bus.mult_begin) begin
            m_cnt <= 0;
            m_end <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= d_lat) m_end <= 1'b1;
        end
    end

    assign bus.mult_end = m_end | stale_end;
    assign bus.product  = smul(bus.mult_op1, bus.mult_op2);

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns in the handshake cycle.
    task automatic wait_hs(input bit id, output int hs_ok);
        hs_ok = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (id == 1'b0 ? (bus.req0_valid && bus.req0_ready)
                           : (bus.req1_valid && bus.req1_ready)) begin
                hs_ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Counts negedges until rsp_valid is seen; -1 if the bound expires.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        int lat;
        int lowcnt;

        resetn         = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_op1   = '0;
        bus.req0_op2   = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op1   = '0;
        bus.req1_op2   = '0;
        #1;
        chk("rst_mult_begin",  64'(bus.mult_begin),  64'd0);
        chk("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
        chk("rst_rsp_id",      64'(bus.rsp_id),      64'd0);
        chk("rst_rsp_product", bus.rsp_product,      64'd0);
        chk("rst_rsp_err",     64'(bus.rsp_err),     64'd0);
        chk("rst_mult_op1",    64'(bus.mult_op1),    64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single requester 0
        @(negedge clk);
        bus.req0_op1   = 32'h0000_1111;
        bus.req0_op2   = 32'h0000_1111;
        bus.req0_valid = 1'b1;
        wait_hs(1'b0, ok);
        chk("t1_handshake", 64'(ok), 64'd1);
        chk("t1_req1_ready", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        chk("t1_mult_begin", 64'(bus.mult_begin), 64'd1);
        chk("t1_mult_op1", 64'(bus.mult_op1), 64'h1111);
        wait_rsp(lat);
        chk("t1_latency", 64'(lat), 64'(d_lat + 2));
        chk("t1_product", bus.rsp_product, 64'h0000_0000_0123_4321);
        chk("t1_id", 64'(bus.rsp_id), 64'd0);
        chk("t1_err", 64'(bus.rsp_err), 64'd0);
        chk("t1_begin_low_resp", 64'(bus.mult_begin), 64'd0);
        @(negedge clk);
        chk("t1_pulse_end", 64'(bus.rsp_valid), 64'd0);
        chk("t1_product_hold", bus.rsp_product, 64'h0000_0000_0123_4321);

        // Stale mult_end in IDLE must not create a response
        stale_end = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("stale_no_begin", 64'(bus.mult_begin), 64'd0);
        end
        stale_end = 1'b0;

        // Simultaneous requests after reset: requester 0 first, then 1
        do_reset();
        @(negedge clk);
        bus.req0_op1   = 32'h0000_1111;
        bus.req0_op2   = 32'h0000_2222;
        bus.req1_op1   = 32'h0000_0002;
        bus.req1_op2   = 32'hFFFF_FFFF;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_hs(1'b0, ok);
        chk("t2_hs0", 64'(ok), 64'd1);
        chk("t2_req1_not_ready", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        wait_rsp(lat);
        chk("t2_product0", bus.rsp_product, 64'h0000_0000_0246_8642);
        chk("t2_id0", 64'(bus.rsp_id), 64'd0);
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mult_begin) break;
            lowcnt++;
            @(negedge clk);
        end
        chk("t2_gap_ge2", 64'(lowcnt >= 2), 64'd1);
        chk("t2_op1_req1", 64'(bus.mult_op1), 64'h2);
        bus.req1_valid = 1'b0;
        wait_rsp(lat);
        chk("t2_latency1", 64'(lat), 64'(d_lat + 1));
        chk("t2_product1", bus.rsp_product, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2_id1", 64'(bus.rsp_id), 64'd1);

        // Both continuously valid: grants alternate 0,1,0,1
        bus.req0_op1   = 32'd3;
        bus.req0_op2   = 32'd5;
        bus.req1_op1   = 32'hFFFF_FFFA;
        bus.req1_op2   = 32'd7;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("t3_no_ready_in_resp0", 64'(bus.req0_ready), 64'd0);
        chk("t3_no_ready_in_resp1", 64'(bus.req1_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(lat);
            chk("t3_rsp_seen", 64'(lat > 0), 64'd1);
            chk("t3_id", 64'(bus.rsp_id), 64'(k % 2));
            chk("t3_product", bus.rsp_product,
                (k % 2 == 0) ? 64'h0000_0000_0000_000F : 64'hFFFF_FFFF_FFFF_FFD6);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset in the middle of WAIT, then retry
        @(negedge clk);
        bus.req1_op1   = 32'd2;
        bus.req1_op2   = 32'h8000_0000;
        bus.req1_valid = 1'b1;
        wait_hs(1'b1, ok);
        chk("t4_hs", 64'(ok), 64'd1);
        repeat (5) @(negedge clk);
        chk("t4_begin_in_wait", 64'(bus.mult_begin), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t4_begin_dropped", 64'(bus.mult_begin), 64'd0);
        chk("t4_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("t4_rsp_id_rst", 64'(bus.rsp_id), 64'd0);
        chk("t4_product_rst", bus.rsp_product, 64'd0);
        repeat (2) @(negedge clk);
        chk("t4_no_rsp_in_rst", 64'(bus.rsp_valid), 64'd0);
        resetn = 1'b1;
        wait_hs(1'b1, ok);
        chk("t4_retry_hs", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        wait_rsp(lat);
        chk("t4_latency", 64'(lat), 64'(d_lat + 2));
        chk("t4_product", bus.rsp_product, 64'hFFFF_FFFF_0000_0000);
        chk("t4_id", 64'(bus.rsp_id), 64'd1);
        chk("t4_err", 64'(bus.rsp_err), 64'd0);

`ifdef MULT_ARB_TIMEOUT_EN
        // Timeout abort: rsp_valid TIMEOUT edges after the handshake edge
        d_lat = 100;
        @(negedge clk);
        bus.req0_op1   = 32'h0000_1111;
        bus.req0_op2   = 32'h0000_2222;
        bus.req0_valid = 1'b1;
        wait_hs(1'b0, ok);
        chk("to_hs", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        wait_rsp(lat);
        chk("to_latency", 64'(lat), 64'(TIMEOUT + 1));
        chk("to_err", 64'(bus.rsp_err), 64'd1);
        chk("to_product", bus.rsp_product, 64'd0);

        // mult_end on the abort edge wins
        d_lat = 63;
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1;
        wait_hs(1'b0, ok);
        chk("prec_hs", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        wait_rsp(lat);
        chk("prec_latency", 64'(lat), 64'(TIMEOUT + 1));
        chk("prec_err", 64'(bus.rsp_err), 64'd0);
        chk("prec_product", bus.rsp_product, 64'h0000_0000_0246_8642);
        d_lat = 33;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
